// File: rtl/washer_pkg.sv
// Shared state codes and actuator decode for the timed washer controller.
// Actuator vectors are ordered {agitator, motor, pump, speed, water_fill}.
package washer_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FILL  = 3'd1;
   localparam logic [2:0] ST_WASH  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_RINSE = 3'd4;
   localparam logic [2:0] ST_SPIN  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   localparam logic [4:0] ACT_OFF   = 5'b00000;
   localparam logic [4:0] ACT_FILL  = 5'b00001;
   localparam logic [4:0] ACT_AGIT  = 5'b11000;
   localparam logic [4:0] ACT_DRAIN = 5'b00100;
   localparam logic [4:0] ACT_SPIN  = 5'b01110;

   function automatic logic [4:0] act_decode(input logic [2:0] st);
      logic [4:0] v;
      case (st)
         ST_FILL:           v = ACT_FILL;
         ST_WASH, ST_RINSE: v = ACT_AGIT;
         ST_DRAIN:          v = ACT_DRAIN;
         ST_SPIN:           v = ACT_SPIN;
         default:           v = ACT_OFF;
      endcase
      return v;
   endfunction

   // Timed states are the only ones the door interlock can pause.
   function automatic logic is_timed(input logic [2:0] st);
      return (st >= ST_FILL) && (st <= ST_SPIN);
   endfunction

endpackage

// File: rtl/washer_ctrl_timed_phase_timer.sv
// Down-counter for one washer phase: load wins, hold freezes, stops at zero.
// zero is a direct decode of the registered count.
module phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic             zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (!hold && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign zero = (r_cnt == '0);

endmodule

// File: rtl/washer_ctrl_timed.sv
// Washing-machine sequencer with internal phase timers, rinse loops, quick mode and door pause.
// Optional abort drain (input abort, pulse output aborted) is built when WASHER_ABORT_EN is defined.
module washer_ctrl_timed
   import washer_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int FILL_TICKS   = 8,
   parameter int WASH_TICKS   = 16,
   parameter int DRAIN_TICKS  = 4,
   parameter int RINSE_TICKS  = 8,
   parameter int SPIN_TICKS   = 8,
   parameter int RINSE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       door,
   input  logic       quick,
`ifdef WASHER_ABORT_EN
   input  logic       abort,
   output logic       aborted,
`endif
   output logic       agitator,
   output logic       motor,
   output logic       pump,
   output logic       speed,
   output logic       water_fill,
   output logic       busy,
   output logic       done,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] L_FILL  = CNT_W'(FILL_TICKS - 1);
   localparam logic [CNT_W-1:0] L_WASH  = CNT_W'(WASH_TICKS - 1);
   localparam logic [CNT_W-1:0] L_DRAIN = CNT_W'(DRAIN_TICKS - 1);
   localparam logic [CNT_W-1:0] L_RINSE = CNT_W'(RINSE_TICKS - 1);
   localparam logic [CNT_W-1:0] L_SPIN  = CNT_W'(SPIN_TICKS - 1);
   localparam logic [2:0]       L_RINSE_CYCLES = 3'(RINSE_CYCLES);

   logic [2:0]       r_state, w_nxt_state;
   logic [2:0]       r_rinse_cnt, w_nxt_rinse_cnt;
   logic             r_rinse_flag, w_nxt_rinse_flag;
   logic             r_quick, w_nxt_quick;
   logic             r_abort_flag, w_nxt_abort_flag;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_zero;
   logic             w_pause;
   logic             w_step;
   logic             w_abort_in;
   logic             w_abort_eff;
   logic [4:0]       w_act;

`ifdef WASHER_ABORT_EN
   assign w_abort_in = abort;
`else
   assign w_abort_in = 1'b0;
`endif

   assign w_pause     = is_timed(r_state) && door;
   assign w_step      = !w_pause && w_zero;
   assign w_abort_eff = r_abort_flag || (w_abort_in && (r_state == ST_DRAIN));

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_load),
      .load_val (w_load_val),
      .hold     (w_pause),
      .zero     (w_zero)
   );

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_rinse_cnt  = r_rinse_cnt;
      w_nxt_rinse_flag = r_rinse_flag;
      w_nxt_quick      = r_quick;
      w_nxt_abort_flag = r_abort_flag;
      w_load           = 1'b0;
      w_load_val       = '0;

      case (r_state)
         ST_IDLE: begin
            if (start && !door) begin
               w_nxt_state      = ST_FILL;
               w_load           = 1'b1;
               w_load_val       = L_FILL;
               w_nxt_quick      = quick;
               w_nxt_rinse_cnt  = quick ? 3'd0 : L_RINSE_CYCLES;
               w_nxt_rinse_flag = 1'b0;
               w_nxt_abort_flag = 1'b0;
            end
         end
         ST_FILL: begin
            if (w_step) begin
               w_load = 1'b1;
               if (r_rinse_flag) begin
                  w_nxt_state      = ST_RINSE;
                  w_load_val       = L_RINSE;
                  w_nxt_rinse_flag = 1'b0;
               end else begin
                  w_nxt_state = ST_WASH;
                  w_load_val  = L_WASH;
               end
            end
         end
         ST_WASH: begin
            if (w_step) begin
               w_nxt_state = ST_DRAIN;
               w_load      = 1'b1;
               w_load_val  = L_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_nxt_abort_flag = w_abort_eff;
            if (w_step) begin
               if (w_abort_eff) begin
                  w_nxt_state      = ST_IDLE;
                  w_nxt_abort_flag = 1'b0;
               end else if ((r_rinse_cnt != 3'd0) && !r_quick) begin
                  w_nxt_state      = ST_FILL;
                  w_nxt_rinse_flag = 1'b1;
                  w_load           = 1'b1;
                  w_load_val       = L_FILL;
               end else begin
                  w_nxt_state = ST_SPIN;
                  w_load      = 1'b1;
                  w_load_val  = L_SPIN;
               end
            end
         end
         ST_RINSE: begin
            if (w_step) begin
               w_nxt_state = ST_DRAIN;
               w_load      = 1'b1;
               w_load_val  = L_DRAIN;
               if (r_rinse_cnt != 3'd0) begin
                  w_nxt_rinse_cnt = r_rinse_cnt - 3'd1;
               end
            end
         end
         ST_SPIN: begin
            if (w_step) begin
               w_nxt_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_nxt_state = ST_IDLE;
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase

      // Abort preempts any normal transition and restarts a full drain.
      if (w_abort_in && (r_state == ST_FILL || r_state == ST_WASH ||
                         r_state == ST_RINSE || r_state == ST_SPIN)) begin
         w_nxt_state      = ST_DRAIN;
         w_load           = 1'b1;
         w_load_val       = L_DRAIN;
         w_nxt_abort_flag = 1'b1;
         w_nxt_rinse_flag = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_rinse_cnt  <= 3'd0;
         r_rinse_flag <= 1'b0;
         r_quick      <= 1'b0;
         r_abort_flag <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_rinse_cnt  <= w_nxt_rinse_cnt;
         r_rinse_flag <= w_nxt_rinse_flag;
         r_quick      <= w_nxt_quick;
         r_abort_flag <= w_nxt_abort_flag;
      end
   end

`ifdef WASHER_ABORT_EN
   logic r_aborted;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aborted <= 1'b0;
      end else begin
         r_aborted <= (r_state == ST_DRAIN) && w_step && w_abort_eff;
      end
   end

   assign aborted = r_aborted;
`endif

   // Door masking is combinational so the drum stops the moment the door opens.
   assign w_act = w_pause ? ACT_OFF : act_decode(r_state);
   assign {agitator, motor, pump, speed, water_fill} = w_act;
   assign busy  = (r_state != ST_IDLE);
   assign done  = (r_state == ST_DONE);
   assign state = r_state;

endmodule

// File: tb/tb_washer_ctrl_timed.sv
// Directed bench for washer_ctrl_timed with short phase timings.
// Cycle n is the clock period following the (n)th edge after start is driven.
module tb_washer_ctrl_timed;

   logic       clk = 1'b0;
   logic       reset, start, door, quick;
   logic       agitator, motor, pump, speed, water_fill, busy, done;
   logic [2:0] state;
   logic       got_ab;
`ifdef WASHER_ABORT_EN
   logic       abort, aborted;
   assign got_ab = aborted;
`else
   assign got_ab = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   washer_ctrl_timed #(
      .CNT_W(16), .FILL_TICKS(3), .WASH_TICKS(4), .DRAIN_TICKS(2),
      .RINSE_TICKS(4), .SPIN_TICKS(3), .RINSE_CYCLES(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .door(door), .quick(quick),
`ifdef WASHER_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
      .water_fill(water_fill), .busy(busy), .done(done), .state(state)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference program for the shared timings, quick=0.
   function automatic logic [2:0] normal_st(input int c);
      if (c >= 1 && c <= 3)   return 3'd1;
      if (c >= 4 && c <= 7)   return 3'd2;
      if (c >= 8 && c <= 9)   return 3'd3;
      if (c >= 10 && c <= 12) return 3'd1;
      if (c >= 13 && c <= 16) return 3'd4;
      if (c >= 17 && c <= 18) return 3'd3;
      if (c >= 19 && c <= 21) return 3'd5;
      if (c == 22)            return 3'd6;
      return 3'd0;
   endfunction

   function automatic logic [2:0] exp_st(input int mode, input int c);
      case (mode)
         1: begin
            if (c <= 9)              return normal_st(c);
            if (c >= 10 && c <= 12)  return 3'd5;
            if (c == 13)             return 3'd6;
            return 3'd0;
         end
         2: begin
            if (c < 5)  return normal_st(c);
            if (c <= 9) return 3'd2;
            return normal_st(c - 5);
         end
         3: begin
            if (c <= 7)  return normal_st(c);
            if (c == 8)  return 3'd2;
            return normal_st(c - 1);
         end
         4: begin
            if (c <= 5)  return normal_st(c);
            if (c <= 7)  return 3'd3;
            return 3'd0;
         end
         5: begin
            if (c <= 20) return normal_st(c);
            return 3'd0;
         end
         default: return normal_st(c);
      endcase
   endfunction

   // {state, agitator, motor, pump, speed, water_fill, busy, done, aborted}
   function automatic logic [10:0] exp_vec(input logic [2:0] st, input logic dr, input logic ab);
      logic [4:0] a;
      case (st)
         3'd1:       a = 5'b00001;
         3'd2, 3'd4: a = 5'b11000;
         3'd3:       a = 5'b00100;
         3'd5:       a = 5'b01110;
         default:    a = 5'b00000;
      endcase
      if (dr && st >= 3'd1 && st <= 3'd5) a = 5'b00000;
      return {st, a, (st != 3'd0), (st == 3'd6), ab};
   endfunction

   function automatic logic [10:0] got_vec();
      return {state, agitator, motor, pump, speed, water_fill, busy, done, got_ab};
   endfunction

   // mode: 0 normal (+ ignored start at 10), 1 quick, 2 door pause 5-9,
   // 3 door on last WASH cycle, 4 abort at 5, 5 reset at 20
   task automatic run(input int mode, input int n);
      for (int c = 0; c <= n; c++) begin
         start = (c == 0) || (mode == 0 && c == 10);
         quick = (c == 0) ? (mode == 1) : (c == 10);
         door  = (mode == 2 && c >= 5 && c <= 9) || (mode == 3 && c == 7);
         reset = (mode == 5 && c == 20);
`ifdef WASHER_ABORT_EN
         abort = (mode == 4 && c == 5);
`endif
         #1;
         chk($sformatf("m%0d_c%0d", mode, c), 16'(got_vec()),
             16'(exp_vec(exp_st(mode, c), door, (mode == 4 && c == 8))));
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      quick = 1'b0;
      door  = 1'b0;
      reset = 1'b0;
`ifdef WASHER_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      door  = 1'b0;
      quick = 1'b0;
`ifdef WASHER_ABORT_EN
      abort = 1'b0;
`endif
      @(posedge clk);
      #1;
      chk("reset", 16'(got_vec()), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Start with door open must be ignored.
      start = 1'b1;
      door  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("door_start_%0d", i), 16'({state, busy}), 16'd0);
      end
      start = 1'b0;
      door  = 1'b0;
      @(posedge clk);
      #1;

      run(0, 24);
      run(1, 15);
      run(2, 29);
      run(3, 25);
      run(5, 24);
      run(0, 24);
`ifdef WASHER_ABORT_EN
      run(4, 10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
